axi_lite_manager: RTL and testbench
===================================

// Module: axi_lite_manager
// PURPOSE
//  Single-outstanding AXI4-Lite manager that drives axi_subordinator from a simple command port.
//  Accepts one read or write command, runs the AR/R or AW/W/B handshakes, returns one response.
//  Sits directly upstream of axi_subordinator and replaces hand-driven bench state machines.
// PARAMETERS
//  ABUS_SIZE  5   address width, matches subordinator ABUS_SIZE
//  DBUS_SIZE  32  data width, matches subordinator DBUS_SIZE
// PORTS
//  ACLK       in   1          clock, all logic on rising edge
//  ARESETn    in   1          asynchronous, active-low reset
//  cmd_valid  in   1          command present
//  cmd_ready  out  1          command accepted when cmd_valid&cmd_ready at a rising edge
//  cmd_write  in   1          1 = write, 0 = read
//  cmd_addr   in   ABUS_SIZE  target address
//  cmd_wdata  in   DBUS_SIZE  write data (ignored for reads)
//  rsp_valid  out  1          response present, held until rsp_ready
//  rsp_ready  in   1          response consumed
//  rsp_data   out  DBUS_SIZE  read data; 0 for writes
//  rsp_resp   out  2          RRESP or BRESP of the transaction
//  ARADDR/ARVALID out, ARREADY in; RDATA[DBUS_SIZE-1:0]/RVALID/RRESP in, RREADY out
//  AWADDR/AWVALID out, AWREADY in; WDATA/WVALID out, WREADY in; BRESP/BVALID in, BREADY out
// BEHAVIOUR
//  Reset (async, ARESETn=0): state IDLE; every output 0 (ARVALID, RREADY, AWVALID, WVALID,
//   BREADY, rsp_valid, cmd_ready); ARADDR/AWADDR/WDATA/rsp_data/rsp_resp 0; aw_done/w_done 0.
//   Asserting reset mid-transaction drops all valids immediately; no transaction resumes.
//  cmd_ready = 1 only in IDLE (and not in reset); one transaction outstanding at a time.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
//  IDLE: on cmd handshake latch addr/data/write.
//   read  -> RD_ADDR: ARADDR=cmd_addr, ARVALID=1.
//   write -> WR_REQ: AWADDR=cmd_addr, WDATA=cmd_wdata, AWVALID=1 and WVALID=1 together.
//  RD_ADDR: ARVALID/ARADDR held stable until ARREADY sampled 1; then ARVALID=0, ARADDR=0,
//   RREADY=1, -> RD_DATA. Valid is never withdrawn before handshake.
//  RD_DATA: on RVALID&RREADY capture RDATA->rsp_data, RRESP->rsp_resp, RREADY=0, -> RESP.
//  WR_REQ: AW and W handshakes tracked independently (aw_done, w_done); AWVALID drops the
//   cycle after its own handshake, WVALID likewise; either order or same cycle is legal.
//   When both done (including both in same edge) -> WR_RESP, BREADY=1, flags cleared.
//  WR_RESP: on BVALID&BREADY capture BRESP->rsp_resp, rsp_data=0, BREADY=0, -> RESP.
//  RESP: rsp_valid=1, rsp_data/rsp_resp stable; on rsp_ready -> IDLE, rsp_valid=0.
//  Latency, zero-wait subordinator (ready/valid already high): cmd handshake at edge 0,
//   rsp_valid high after edge 2 (read) or edge 2 (write, AW/W at edge 1, B at edge 2).
//   Each subordinator wait cycle adds exactly one cycle.
//  Responses SLVERR/DECERR are passed through unchanged; no retry.
//  Inputs RVALID/BVALID outside their states are ignored.
// TESTING
//  1 Reset: hold ARESETn=0 5 cycles -> all outputs 0, cmd_ready=0; release -> cmd_ready=1 next edge.
//  2 Read: RAM[2]=2, cmd read addr 2 -> ARADDR=2 one handshake, rsp_valid with rsp_data=2, rsp_resp=0,
//    rsp_valid 2 edges after cmd handshake.
//  3 Write then read: write 5 to addr 3 -> BRESP=0 returned, RAM[3]=5; read addr 3 -> rsp_data=5.
//  4 Wait states via stub: AWREADY 3 cycles late, WREADY immediate -> WVALID drops first, AWVALID
//    held with AWADDR stable, single B, single response.
//  5 Backpressure: rsp_ready=0 for 4 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, no new AR.
//  6 Reset mid-op: ARESETn=0 while ARVALID=1 and ARREADY=0 -> ARVALID=0 same cycle (async),
//    after release a new read of addr 1 returns 1.

Source files
------------

// File: rtl/axi_lite_manager.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_manager
// Description : Single-outstanding AXI4-Lite manager. Takes one read or write
//               command from a simple valid/ready port, runs the AR/R or
//               AW/W/B handshakes and returns one held response.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_manager #(
  parameter int ABUS_SIZE = 5,
  parameter int DBUS_SIZE = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  // command / response port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ABUS_SIZE-1:0] cmd_addr,
  input  logic [DBUS_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DBUS_SIZE-1:0] rsp_data,
  output logic [1:0]           rsp_resp,
  // read address / data channels
  output logic [ABUS_SIZE-1:0] ARADDR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [DBUS_SIZE-1:0] RDATA,
  input  logic                 RVALID,
  input  logic [1:0]           RRESP,
  output logic                 RREADY,
  // write address / data / response channels
  output logic [ABUS_SIZE-1:0] AWADDR,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [DBUS_SIZE-1:0] WDATA,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_rst_done;
  logic r_aw_done;
  logic r_w_done;
  logic w_aw_done_nxt;
  logic w_w_done_nxt;

  logic w_cmd_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_wr_both;

  // Handshake strobes are pure state decodes, so an async reset (state back
  // to IDLE) drops every valid/ready in the same instant.
  assign cmd_ready = (r_state == S_IDLE) && r_rst_done;
  assign ARVALID   = (r_state == S_RD_ADDR);
  assign RREADY    = (r_state == S_RD_DATA);
  assign AWVALID   = (r_state == S_WR_REQ) && !r_aw_done;
  assign WVALID    = (r_state == S_WR_REQ) && !r_w_done;
  assign BREADY    = (r_state == S_WR_RESP);
  assign rsp_valid = (r_state == S_RESP);

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_ar_hs   = ARVALID && ARREADY;
  assign w_r_hs    = RVALID && RREADY;
  assign w_aw_hs   = AWVALID && AWREADY;
  assign w_w_hs    = WVALID && WREADY;
  assign w_b_hs    = BVALID && BREADY;
  // Both write channels complete, counting a handshake landing on this edge.
  assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and next value of the per-channel write-done flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = 1'b0;
    w_w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_state_nxt = cmd_write ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        if (w_ar_hs) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (w_r_hs) w_state_nxt = S_RESP;
      end
      S_WR_REQ: begin
        if (w_wr_both) begin
          w_state_nxt = S_WR_RESP;
        end else begin
          w_aw_done_nxt = r_aw_done || w_aw_hs;
          w_w_done_nxt  = r_w_done || w_w_hs;
        end
      end
      S_WR_RESP: begin
        if (w_b_hs) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write-done flags and the one-cycle hold-off of cmd_ready after reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Address/data/response registers; ARADDR returns to zero once accepted.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ARADDR   <= '0;
      AWADDR   <= '0;
      WDATA    <= '0;
      rsp_data <= '0;
      rsp_resp <= 2'b00;
    end else begin
      if (w_cmd_hs) begin
        if (cmd_write) begin
          AWADDR <= cmd_addr;
          WDATA  <= cmd_wdata;
        end else begin
          ARADDR <= cmd_addr;
        end
      end
      if (w_ar_hs) ARADDR <= '0;
      if (w_r_hs) begin
        rsp_data <= RDATA;
        rsp_resp <= RRESP;
      end
      if (w_b_hs) begin
        rsp_data <= '0;
        rsp_resp <= BRESP;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_manager
// Description : Self-checking bench for axi_lite_manager with a wait-state
//               programmable AXI4-Lite subordinate stub and a transaction-level
//               reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_manager;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [4:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic [1:0]  RRESP;
  logic        RREADY;
  logic [4:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  int tests = 0;
  int fails = 0;

  axi_lite_manager #(.ABUS_SIZE(5), .DBUS_SIZE(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RRESP(RRESP), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Subordinate address map: 24..27 answer SLVERR, 28..31 DECERR.
  function automatic logic [1:0] resp_of(input logic [4:0] a);
    if (a >= 5'd28) return 2'b11;
    if (a >= 5'd24) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- subordinate stub ----------------
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit r_pend, b_pend, aw_got, w_got;
  bit stray = 1'b0;
  logic [4:0]  rd_addr_q, aw_addr_q;
  logic [31:0] w_data_q;
  logic [31:0] mem [32];

  assign ARREADY = ARVALID && (ar_cnt >= ar_wait);
  assign AWREADY = AWVALID && (aw_cnt >= aw_wait);
  assign WREADY  = WVALID && (w_cnt >= w_wait);
  assign RVALID  = (r_pend && (r_cnt >= r_wait)) || stray;
  assign RRESP   = resp_of(rd_addr_q);
  assign RDATA   = (resp_of(rd_addr_q) == 2'b00) ? mem[rd_addr_q] : (32'hBAD0_0000 | 32'(rd_addr_q));
  assign BVALID  = (b_pend && (b_cnt >= b_wait)) || stray;
  assign BRESP   = resp_of(aw_addr_q);

  always @(posedge ACLK or negedge ARESETn) begin
    logic aw_n, w_n;
    logic [4:0] wa;
    logic [31:0] wd;
    if (!ARESETn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0;
      rd_addr_q <= '0; aw_addr_q <= '0; w_data_q <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else begin
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      if (ARVALID && ARREADY) begin
        rd_addr_q <= ARADDR; r_pend <= 1; r_cnt <= 0;
      end else if (RVALID && RREADY) r_pend <= 0;
      else if (r_pend) r_cnt <= r_cnt + 1;
      aw_n = aw_got || (AWVALID && AWREADY);
      w_n  = w_got || (WVALID && WREADY);
      wa   = (AWVALID && AWREADY) ? AWADDR : aw_addr_q;
      wd   = (WVALID && WREADY) ? WDATA : w_data_q;
      if (AWVALID && AWREADY) aw_addr_q <= AWADDR;
      if (WVALID && WREADY) w_data_q <= WDATA;
      if (aw_n && w_n) begin
        b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
        if (resp_of(wa) == 2'b00) mem[wa] <= wd;
      end else begin
        aw_got <= aw_n; w_got <= w_n;
        if (BVALID && BREADY) b_pend <= 0;
        else if (b_pend) b_cnt <= b_cnt + 1;
      end
    end
  end

  // ---------------- handshake counters ----------------
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, r_hs = 0;
  always @(posedge ACLK) begin
    if (ARVALID && ARREADY) ar_hs++;
    if (AWVALID && AWREADY) aw_hs++;
    if (WVALID && WREADY) w_hs++;
    if (BVALID && BREADY) b_hs++;
    if (RVALID && RREADY) r_hs++;
  end

  // ---------------- channel protocol monitor ----------------
  logic p_rstn = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic [4:0]  p_araddr = '0, p_awaddr = '0;
  logic [31:0] p_wdata = '0;
  always @(negedge ACLK) begin
    if (ARESETn && p_rstn) begin
      if (p_arv && !p_arr) check("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
      if (p_arv && p_arr)  check("ar_drop", ARVALID, 1'b0);
      if (p_awv && !p_awr) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      if (p_awv && p_awr)  check("aw_drop", AWVALID, 1'b0);
      if (p_wv && !p_wr)   check("w_hold", {WVALID, WDATA}, {1'b1, p_wdata});
      if (p_wv && p_wr)    check("w_drop", WVALID, 1'b0);
    end
    p_rstn = ARESETn;
    p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
    p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
    p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [32];

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
  endtask

  // One full command: drive, expect latency = 2 + summed waits, hold the
  // response for bp cycles, then consume it.
  task automatic do_txn(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                        input int kar, input int kr, input int kaw, input int kw,
                        input int kb, input int bp);
    int n, lat, ar0, aw0, w0, b0, r0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_r = resp_of(addr);
    if (wr) begin
      exp_d = 32'd0;
      if (exp_r == 2'b00) ref_mem[addr] = data;
      lat = 2 + ((kaw > kw) ? kaw : kw) + kb;
    end else begin
      exp_d = (exp_r == 2'b00) ? ref_mem[addr] : (32'hBAD0_0000 | 32'(addr));
      lat = 2 + kar + kr;
    end
    ar_wait = kar; r_wait = kr; aw_wait = kaw; w_wait = kw; b_wait = kb;
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = r_hs;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge ACLK); #1; n++; end
    check("cmd_ready_seen", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0; cmd_addr = 5'($urandom); cmd_wdata = $urandom;
    check("cmd_ready_busy", cmd_ready, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge ACLK); #1; n++; end
    check(wr ? "wr_latency" : "rd_latency", n, lat);
    check(wr ? "wr_rsp_data" : "rd_rsp_data", rsp_data, exp_d);
    check(wr ? "wr_rsp_resp" : "rd_rsp_resp", rsp_resp, exp_r);
    for (int i = 0; i < bp; i++) begin
      @(posedge ACLK); #1;
      check("bp_hold", {rsp_valid, cmd_ready, ARVALID, AWVALID, rsp_resp, rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, exp_r, exp_d});
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    check("rsp_consumed", {rsp_valid, cmd_ready}, 2'b01);
    check("hs_counts", {8'(ar_hs - ar0), 8'(r_hs - r0), 8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)},
          wr ? {8'd0, 8'd0, 8'd1, 8'd1, 8'd1} : {8'd1, 8'd1, 8'd0, 8'd0, 8'd0});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    ref_reset();
    // reset held for 5 cycles
    repeat (5) @(posedge ACLK);
    #1;
    check("reset_ctrl", {cmd_ready, ARVALID, RREADY, AWVALID, WVALID, BREADY, rsp_valid}, 7'd0);
    check("reset_data", {ARADDR, AWADDR, WDATA, rsp_data, rsp_resp}, 76'd0);
    ARESETn = 1'b1;
    #1;
    check("release_cmd_ready_0", cmd_ready, 1'b0);
    @(posedge ACLK); #1;
    check("release_cmd_ready_1", cmd_ready, 1'b1);

    // zero-wait read of addr 2
    do_txn(1'b0, 5'd2, 32'd0, 0, 0, 0, 0, 0, 0);
    // write 5 to addr 3 then read it back
    do_txn(1'b1, 5'd3, 32'd5, 0, 0, 0, 0, 0, 0);
    do_txn(1'b0, 5'd3, 32'd0, 0, 0, 0, 0, 0, 0);
    // AWREADY 3 cycles late, WREADY immediate
    do_txn(1'b1, 5'd7, 32'hCAFE_0007, 0, 0, 3, 0, 0, 0);
    do_txn(1'b1, 5'd8, 32'hCAFE_0008, 0, 0, 0, 2, 1, 0);
    // response backpressure for 4 cycles
    do_txn(1'b0, 5'd7, 32'd0, 1, 1, 0, 0, 0, 4);
    // error responses pass through
    do_txn(1'b1, 5'd25, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    do_txn(1'b0, 5'd30, 32'd0, 0, 0, 0, 0, 0, 1);

    // stray RVALID/BVALID while idle are ignored
    stray = 1'b1;
    repeat (3) begin
      @(posedge ACLK); #1;
      check("stray_ignored", {RREADY, BREADY, rsp_valid, cmd_ready}, 4'b0001);
    end
    stray = 1'b0;

    // reset while ARVALID is waiting on ARREADY
    ar_wait = 10;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd4;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    @(posedge ACLK); #1;
    check("midop_arvalid_up", {ARVALID, ARREADY}, 2'b10);
    ARESETn = 1'b0;
    ref_reset();
    #1;
    check("midop_arvalid_drop", {ARVALID, cmd_ready, rsp_valid, ARADDR}, 8'd0);
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    do_txn(1'b0, 5'd1, 32'd0, 0, 0, 0, 0, 0, 0);

    // randomized traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), 5'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
